// File: rtl/wasm_core.sv
// Tiny WebAssembly-subset interpreter: a FETCH/EXEC/HALT machine over an
// 8-deep 64-bit operand stack, fed by a synchronous 16-byte ROM window.
module wasm_core #(
    parameter int MEM_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [63:0]          result,
    output logic                 result_empty,
    output logic [3:0]           trap,
    output logic [MEM_DEPTH:0]   mem_addr,
    output logic [3:0]           mem_extra,
    input  logic [127:0]         mem_data,
    input  logic                 mem_error
);
    // No valid/ready handshake: the ROM answers mem_addr exactly one cycle
    // later, so FETCH presents the PC and EXEC consumes the returned window.
    typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, HALT = 2'd2} state_t;

    // Declaration values give the reset state at power-up as well.
    state_t               state = FETCH;
    state_t               next_state;
    logic [MEM_DEPTH:0]   pc = '0;
    logic [3:0]           sp = '0;
    logic [3:0]           trap_q = '0;
    logic [63:0]          stack [0:7];

    logic [7:0]  opcode;
    logic [2:0]  sp_m1, sp_m2, push_idx;
    logic [63:0] top, second;
    logic [2:0]  leb_len;
    logic [34:0] leb_raw;
    logic [31:0] leb_val;
    logic        ex_halt, ex_push;
    logic [3:0]  ex_trap;
    logic [2:0]  ex_len;
    logic [1:0]  ex_pop;
    logic [63:0] ex_val;
    logic [3:0]  sp_next;
    logic        unused_bits;

    assign opcode   = mem_data[7:0];
    assign sp_m1    = 3'(sp - 4'd1);
    assign sp_m2    = 3'(sp - 4'd2);
    assign top      = stack[sp_m1];
    assign second   = stack[sp_m2];
    assign sp_next  = sp - {2'b00, ex_pop} + {3'b000, ex_push};
    assign push_idx = 3'(sp_next - 4'd1);
    assign unused_bits = ^{mem_data[127:48], leb_raw[34:32], second[63:32]};

    // Signed LEB128: length is the first byte (of up to 5) with bit 7 clear;
    // length 0 means the encoding runs past 5 bytes.
    always_comb begin
        leb_len = 3'd0;
        for (int k = 5; k >= 1; k--)
            if (!mem_data[8*k+7]) leb_len = 3'(k);
        leb_raw = '0;
        for (int k = 0; k < 5; k++)
            if (3'(k) < leb_len) leb_raw[7*k +: 7] = mem_data[8*k+8 +: 7];
        leb_val = leb_raw[31:0];
        case (leb_len)
            3'd1: if (leb_raw[6])  leb_val[31:7]  = '1;
            3'd2: if (leb_raw[13]) leb_val[31:14] = '1;
            3'd3: if (leb_raw[20]) leb_val[31:21] = '1;
            3'd4: if (leb_raw[27]) leb_val[31:28] = '1;
            default: ;
        endcase
    end

    // Instruction decode; a halting instruction leaves PC and stack untouched.
    always_comb begin
        ex_halt = 1'b0;
        ex_trap = 4'd0;
        ex_len  = 3'd1;
        ex_pop  = 2'd0;
        ex_push = 1'b0;
        ex_val  = '0;
        if (mem_error) begin
            ex_halt = 1'b1;
            ex_trap = 4'd5;
        end else begin
            case (opcode)
                8'h41: begin
                    if (leb_len == 3'd0) begin
                        ex_halt = 1'b1; ex_trap = 4'd6;
                    end else if (sp == 4'd8) begin
                        ex_halt = 1'b1; ex_trap = 4'd3;
                    end else begin
                        ex_push = 1'b1;
                        ex_val  = {32'd0, leb_val};
                        ex_len  = leb_len + 3'd1;
                    end
                end
                8'h45, 8'h1A: begin
                    if (sp < 4'd1) begin
                        ex_halt = 1'b1; ex_trap = 4'd2;
                    end else begin
                        ex_pop  = 2'd1;
                        ex_push = (opcode == 8'h45);
                        ex_val  = {63'd0, top[31:0] == 32'd0};
                    end
                end
                8'h46, 8'h47, 8'h6A, 8'h6B: begin
                    if (sp < 4'd2) begin
                        ex_halt = 1'b1; ex_trap = 4'd2;
                    end else begin
                        ex_pop  = 2'd2;
                        ex_push = 1'b1;
                        case (opcode)
                            8'h46:   ex_val = {63'd0, second[31:0] == top[31:0]};
                            8'h47:   ex_val = {63'd0, second[31:0] != top[31:0]};
                            8'h6A:   ex_val = {32'd0, second[31:0] + top[31:0]};
                            default: ex_val = {32'd0, second[31:0] - top[31:0]};
                        endcase
                    end
                end
                8'h01: ;
                8'h0B: ex_halt = 1'b1;
                8'h00: begin ex_halt = 1'b1; ex_trap = 4'd1; end
                default: begin ex_halt = 1'b1; ex_trap = 4'd4; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:   next_state = EXEC;
            EXEC:    next_state = ex_halt ? HALT : FETCH;
            default: next_state = HALT;
        endcase
    end

    always_comb begin
        mem_addr     = pc;
        mem_extra    = 4'hF;
        result_empty = (sp == 4'd0);
        result       = (sp == 4'd0) ? 64'd0 : top;
        trap         = trap_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= '0;
            sp     <= '0;
            trap_q <= '0;
        end else if (state == EXEC) begin
            if (ex_halt) begin
                trap_q <= ex_trap;
            end else begin
                pc <= pc + (MEM_DEPTH+1)'(ex_len);
                sp <= sp_next;
            end
        end
    end

    // Stack contents need no reset: entries above sp are never observed.
    always_ff @(posedge clk) begin
        if (!reset && state == EXEC && !ex_halt && ex_push)
            stack[push_idx] <= ex_val;
    end
endmodule

// File: tb/tb_wasm_core.sv
// Directed bench for wasm_core: a 32-byte synchronous ROM model, one task per
// scenario with hand-computed expectations, and a single summary line.
module tb_wasm_core;
    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [63:0]   result;
    logic          result_empty;
    logic [3:0]    trap;
    logic [4:0]    mem_addr;
    logic [3:0]    mem_extra;
    logic [127:0]  mem_data = '0;
    logic          mem_error = 1'b0;

    logic [7:0]    rom [0:31];
    logic [7:0]    prog_q [$];
    int            total = 0;
    int            bad = 0;

    wasm_core #(.MEM_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .result(result), .result_empty(result_empty),
        .trap(trap), .mem_addr(mem_addr), .mem_extra(mem_extra),
        .mem_data(mem_data), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    // ROM answers one cycle after the address; windows past byte 31 are errors.
    always @(posedge clk) begin
        for (int k = 0; k < 16; k++)
            mem_data[8*k +: 8] <= rom[5'(int'(mem_addr) + k)];
        mem_error <= (int'(mem_addr) + 15 > 31);
    end

    task automatic load_prog();
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        for (int i = 0; i < prog_q.size(); i++) rom[i] = prog_q[i];
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
    endtask

    task automatic run_prog(input int n);
        load_prog();
        pulse_reset();
        cycles(n);
    endtask

    task automatic test_power_up();
        prog_q = '{8'h41, 8'h05, 8'h45, 8'h0B};
        load_prog();
        cycles(3);
        total++; if (result !== 64'd5) begin bad++; $display("FAIL pwr_const result=%0h want 5", result); end
        cycles(1);
        total++; if (result !== 64'd0) begin bad++; $display("FAIL pwr_eqz result=%0h want 0", result); end
        cycles(5);
        total++; if (result !== 64'd0 || result_empty !== 1'b0 || trap !== 4'd0) begin
            bad++; $display("FAIL pwr_final result=%0h empty=%b trap=%0d want 0/0/0", result, result_empty, trap);
        end
    endtask

    task automatic test_reset();
        pulse_reset();
        total++; if (result !== 64'd0 || result_empty !== 1'b1 || trap !== 4'd0) begin
            bad++; $display("FAIL reset_out result=%0h empty=%b trap=%0d want 0/1/0", result, result_empty, trap);
        end
        total++; if (mem_addr !== 5'd0 || mem_extra !== 4'hF) begin
            bad++; $display("FAIL reset_mem addr=%0d extra=%0h want 0/F", mem_addr, mem_extra);
        end
    endtask

    task automatic test_eqz_true();
        prog_q = '{8'h41, 8'h00, 8'h45, 8'h0B};
        run_prog(12);
        total++; if (result !== 64'd1 || result_empty !== 1'b0 || trap !== 4'd0) begin
            bad++; $display("FAIL eqz_true result=%0h empty=%b trap=%0d want 1/0/0", result, result_empty, trap);
        end
    endtask

    task automatic test_arith();
        prog_q = '{8'h41, 8'h7F, 8'h41, 8'h03, 8'h6A, 8'h0B};
        run_prog(14);
        total++; if (result !== 64'd2 || trap !== 4'd0) begin
            bad++; $display("FAIL add result=%0h trap=%0d want 2/0", result, trap);
        end
        prog_q = '{8'h41, 8'h00, 8'h41, 8'h01, 8'h6B, 8'h0B};
        run_prog(14);
        total++; if (result !== 64'h0000_0000_FFFF_FFFF || trap !== 4'd0) begin
            bad++; $display("FAIL sub_wrap result=%0h trap=%0d want ffffffff/0", result, trap);
        end
        prog_q = '{8'h41, 8'h05, 8'h41, 8'h05, 8'h46, 8'h41, 8'h05, 8'h41, 8'h06, 8'h47, 8'h6A, 8'h0B};
        run_prog(24);
        total++; if (result !== 64'd2 || trap !== 4'd0) begin
            bad++; $display("FAIL eq_ne result=%0h trap=%0d want 2/0", result, trap);
        end
    endtask

    task automatic test_leb();
        prog_q = '{8'h41, 8'hE5, 8'h8E, 8'h26, 8'h0B};
        run_prog(10);
        total++; if (result !== 64'h98765) begin bad++; $display("FAIL leb3 result=%0h want 98765", result); end
        prog_q = '{8'h41, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'h0B};
        run_prog(10);
        total++; if (result !== 64'hFFFF_FFFF || trap !== 4'd0) begin
            bad++; $display("FAIL leb5 result=%0h trap=%0d want ffffffff/0", result, trap);
        end
        prog_q = '{8'h41, 8'h40, 8'h0B};
        run_prog(10);
        total++; if (result !== 64'hFFFF_FFC0) begin bad++; $display("FAIL leb_sign result=%0h want ffffffc0", result); end
        prog_q = '{8'h41, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00};
        run_prog(10);
        total++; if (trap !== 4'd6 || result_empty !== 1'b1) begin
            bad++; $display("FAIL leb_long trap=%0d empty=%b want 6/1", trap, result_empty);
        end
    endtask

    task automatic test_underflow();
        prog_q = '{8'h45, 8'h0B};
        run_prog(20);
        total++; if (trap !== 4'd2 || result_empty !== 1'b1 || result !== 64'd0) begin
            bad++; $display("FAIL underflow trap=%0d empty=%b result=%0h want 2/1/0", trap, result_empty, result);
        end
        prog_q = '{8'h41, 8'h01, 8'h6A, 8'h0B};
        run_prog(20);
        total++; if (trap !== 4'd2 || result !== 64'd1) begin
            bad++; $display("FAIL underflow_bin trap=%0d result=%0h want 2/1", trap, result);
        end
    endtask

    task automatic test_drop_nop();
        prog_q = '{8'h41, 8'h01, 8'h1A, 8'h0B};
        run_prog(12);
        total++; if (result_empty !== 1'b1 || trap !== 4'd0) begin
            bad++; $display("FAIL drop empty=%b trap=%0d want 1/0", result_empty, trap);
        end
        prog_q = '{8'h01, 8'h41, 8'h02, 8'h01, 8'h0B};
        run_prog(12);
        total++; if (result !== 64'd2 || trap !== 4'd0) begin
            bad++; $display("FAIL nop result=%0h trap=%0d want 2/0", result, trap);
        end
    endtask

    task automatic test_traps();
        prog_q = '{8'hFF};
        run_prog(6);
        total++; if (trap !== 4'd4) begin bad++; $display("FAIL bad_opcode trap=%0d want 4", trap); end
        prog_q = '{8'h00};
        run_prog(6);
        total++; if (trap !== 4'd1) begin bad++; $display("FAIL unreachable trap=%0d want 1", trap); end
        prog_q = '{8'h41, 8'h01, 8'h41, 8'h02, 8'h41, 8'h03, 8'h41, 8'h04, 8'h41, 8'h05,
                   8'h41, 8'h06, 8'h41, 8'h07, 8'h41, 8'h08, 8'h41, 8'h09, 8'h0B};
        run_prog(30);
        total++; if (trap !== 4'd3 || result !== 64'd8) begin
            bad++; $display("FAIL overflow trap=%0d result=%0h want 3/8", trap, result);
        end
        cycles(10);
        total++; if (trap !== 4'd3) begin bad++; $display("FAIL trap_hold trap=%0d want 3", trap); end
        prog_q = {};
        for (int i = 0; i < 17; i++) prog_q.push_back(8'h01);
        prog_q.push_back(8'h0B);
        run_prog(50);
        total++; if (trap !== 4'd5) begin bad++; $display("FAIL mem_error trap=%0d want 5", trap); end
    endtask

    task automatic test_reset_mid();
        prog_q = '{8'h41, 8'h7F, 8'h41, 8'h03, 8'h6A, 8'h0B};
        run_prog(3);
        total++; if (result !== 64'hFFFF_FFFF) begin bad++; $display("FAIL mid_pre result=%0h want ffffffff", result); end
        pulse_reset();
        total++; if (result_empty !== 1'b1 || mem_addr !== 5'd0) begin
            bad++; $display("FAIL mid_reset empty=%b addr=%0d want 1/0", result_empty, mem_addr);
        end
        cycles(14);
        total++; if (result !== 64'd2 || trap !== 4'd0) begin
            bad++; $display("FAIL mid_rerun result=%0h trap=%0d want 2/0", result, trap);
        end
    endtask

    initial begin
        test_power_up();
        test_reset();
        test_eqz_true();
        test_arith();
        test_leb();
        test_underflow();
        test_drop_nop();
        test_traps();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wasm_core.md
WASM_CORE -- requirements
Module: wasm_core

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 4, meaning the width of the ROM address minus one; mem_addr is MEM_DEPTH+1 bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port result, output, 64 bits: the value on top of the operand stack, or 0 when the stack is empty.
REQ-005 SHALL have port result_empty, output, 1 bit: high when the operand stack holds 0 entries.
REQ-006 SHALL have port trap, output, 4 bits: trap code; 0 means no trap.
REQ-007 SHALL have port mem_addr, output, MEM_DEPTH+1 bits: byte address of the instruction fetch (the PC).
REQ-008 SHALL have port mem_extra, output, 4 bits: number of bytes requested minus one; always driven as 4'hF (16-byte window).
REQ-009 SHALL have port mem_data, input, 128 bits: fetch window; bits [7:0] hold the byte at mem_addr, and bits [8k+7:8k] hold the byte at mem_addr+k.
REQ-010 SHALL have port mem_error, input, 1 bit: high when the fetched window is out of ROM bounds.

Function
REQ-011 SHALL treat the ROM as synchronous: mem_data and mem_error are valid one cycle after mem_addr is driven.
REQ-012 SHALL implement the states FETCH, EXEC and HALT.
- FETCH: drive mem_addr = PC, go to EXEC.
- EXEC: decode mem_data[7:0], execute, advance PC by the instruction length, return to FETCH or go to HALT.
- HALT: absorbing until reset.
REQ-013 SHALL keep an 8-entry × 64-bit operand stack; i32 values are stored zero-extended.
REQ-014 SHALL decode opcode 0x41 i32.const: signed LEB128 immediate of 1 to 5 bytes; push the low 32 bits zero-extended; PC += 1 + LEB length.
REQ-015 SHALL decode opcode 0x45 i32.eqz: pop a; push 1 if a[31:0]==0, else 0.
REQ-016 SHALL decode opcodes 0x46 i32.eq and 0x47 i32.ne: pop b, then a; push the 0/1 comparison of their low 32 bits.
REQ-017 SHALL decode opcodes 0x6A i32.add and 0x6B i32.sub: pop b, then a; push (a op b) mod 2^32, zero-extended.
REQ-018 SHALL decode opcode 0x1A drop (pop and discard) and opcode 0x01 nop (no effect); PC += 1 for each.
REQ-019 SHALL decode opcode 0x0B end: go to HALT with trap 0; the stack is unchanged.
REQ-020 SHALL decode opcode 0x00 unreachable: go to HALT with trap 1.
REQ-021 SHALL, on a pop from an empty stack (or one with too few operands), go to HALT with trap 2 and leave the stack unchanged.
REQ-022 SHALL, on a push to a full stack (8 entries; the net push of a binary op never overflows), go to HALT with trap 3.
REQ-023 SHALL, on any other opcode, go to HALT with trap 4.
REQ-024 SHALL, when mem_error is high in EXEC, go to HALT with trap 5 without executing.
REQ-025 SHALL, on a LEB128 immediate longer than 5 bytes, go to HALT with trap 6.
REQ-026 SHALL update trap only on entry to HALT and hold it thereafter.
REQ-027 SHALL wrap the PC modulo 2^(MEM_DEPTH+1).
REQ-028 SHALL take exactly 2 cycles per instruction; a three-instruction program (const, eqz, end) SHALL reach HALT within 6 cycles of start.
REQ-029 SHALL update result and result_empty combinationally from the stack pointer and stack top.

Reset
REQ-030 SHALL, while reset is high at a rising edge, set: state=FETCH, PC=0, stack pointer=0, trap=0, result=0, result_empty=1, mem_addr=0.
REQ-031 SHALL take the same values from power-up initialisation, so the core runs correctly when reset is never asserted.
REQ-032 SHALL let reset take effect from any state, including mid-instruction and HALT; fetch restarts at PC 0 on the cycle after reset deasserts.

Verification
REQ-033 SHALL be verified with: ROM 41 05 45 0B, no reset -> by cycle 9: result=0, result_empty=0, trap=0.
REQ-034 SHALL be verified with: ROM 41 00 45 0B -> result=1, result_empty=0, trap=0.
REQ-035 SHALL be verified with: ROM 41 7F 41 03 6A 0B (-1 + 3) -> result=2, trap=0.
REQ-036 SHALL be verified with: ROM 45 0B -> trap=2, result_empty=1, result=0.
REQ-037 SHALL be verified with: ROM 41 01 1A 0B -> result_empty=1, trap=0; then separately ROM FF -> trap=4.
REQ-038 SHALL be verified with: reset pulsed mid-program -> the stack is emptied and the program reruns to the same final result.
